// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Adds two WIDTH-bit operands by time-sharing one external 4-bit adder.
//   One 4-bit slice per cycle, LSB slice first. The carry out of each slice
//   is registered and fed into the next slice.
// Ports
//   clk, rst               rising-edge clock; asynchronous active-high reset
//   start_valid/ready      request handshake; A, B, Cin sampled on it
//   A, B, Cin              operands and carry-in
//   add_A/add_B/add_Cin    slice sent to the shared adder (0 outside RUN)
//   add_S/add_Cout         combinational result from the shared adder
//   S, Cout                result; held while done_valid
//   done_valid/ready       result handshake
//   busy                   high while running or holding a result
module multiword_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [3:0]       add_A,
  output logic [3:0]       add_B,
  output logic             add_Cin,
  input  logic [3:0]       add_S,
  input  logic             add_Cout,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("multiword_add_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic                   cout_q, cout_d;
  logic [NSLICE-1:0][3:0] opa_q, opa_d;
  logic [NSLICE-1:0][3:0] opb_q, opb_d;
  logic [NSLICE-1:0][3:0] s_q, s_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    s_d     = s_q;
    add_A   = '0;
    add_B   = '0;
    add_Cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          opa_d   = A;
          opb_d   = B;
          carry_d = Cin;
          idx_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_A        = opa_q[idx_q];
        add_B        = opb_q[idx_q];
        add_Cin      = carry_q;
        s_d[idx_q]   = add_S;
        carry_d      = add_Cout;
        if (idx_q == IDXW'(NSLICE - 1)) begin
          cout_d  = add_Cout;
          idx_d   = '0;  // explicit wrap: NSLICE need not be a power of two
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      s_q     <= s_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign S           = s_q;
  assign Cout        = cout_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Cin = 1'b0;
  logic [3:0]       add_A, add_B, add_S;
  logic             add_Cin, add_Cout;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             done_valid;
  logic             done_ready = 1'b1;
  logic             busy;

  int nchk = 0;
  int nerr = 0;

  logic [3:0] seq_a [16];
  logic [3:0] seq_b [16];

  always #5 clk = ~clk;

  // Shared 4-bit adder living outside the sequencer.
  assign {add_Cout, add_S} = 5'(add_A) + 5'(add_B) + 5'(add_Cin);

  multiword_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .A(A), .B(B), .Cin(Cin),
    .add_A(add_A), .add_B(add_B), .add_Cin(add_Cin),
    .add_S(add_S), .add_Cout(add_Cout),
    .S(S), .Cout(Cout),
    .done_valid(done_valid), .done_ready(done_ready),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a request once start_ready is seen; returns after the accept edge.
  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int n = 0;
    while (!start_ready && n < 50) begin tick(); n++; end
    chk("start_ready_before_req", 32'(start_ready), 1);
    A = a; B = b; Cin = cin; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    // Operand lines are scrambled after the handshake; the result must not care.
    A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
  endtask

  // Wait for done_valid, recording adder slices; checks latency and result.
  task automatic wait_done(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           output int lat);
    logic [16:0] e;
    int n = 0;
    while (!done_valid && n < 50) begin
      if (n < 16) begin seq_a[n] = add_A; seq_b[n] = add_B; end
      tick(); n++;
    end
    lat = n;
    e = 17'(a) + 17'(b) + 17'(cin);
    chk("latency", 32'(lat), NSLICE);
    chk("S", 32'(S), 32'(e[15:0]));
    chk("Cout", 32'(Cout), 32'(e[16]));
  endtask

  // Drain the result; with rnd, done_ready toggles randomly while S is re-checked.
  task automatic finish(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input bit rnd);
    logic [16:0] e;
    int m = 0;
    e = 17'(a) + 17'(b) + 17'(cin);
    do begin
      done_ready = rnd ? 1'($urandom) : 1'b1;
      tick(); m++;
      if (done_valid) chk("S_held", 32'({Cout, S}), 32'(e));
    end while (done_valid && m < 60);
    chk("done_drained", 32'(done_valid), 0);
    done_ready = 1'b1;
  endtask

  initial begin : main
    int lat;
    bit seen;
    logic [15:0] ra, rb;
    logic rc;

    // Reset state
    #12; rst = 1'b0; #1;
    tick();
    chk("rst_S", 32'(S), 0);
    chk("rst_Cout", 32'(Cout), 0);
    chk("rst_done_valid", 32'(done_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start_ready", 32'(start_ready), 1);
    chk("rst_add", 32'({add_A, add_B, add_Cin}), 0);

    // Zero operands
    start(16'h0000, 16'h0000, 1'b0);
    wait_done(16'h0000, 16'h0000, 1'b0, lat);
    finish(16'h0000, 16'h0000, 1'b0, 1'b0);

    // Carry ripples through every slice
    start(16'hFFFF, 16'h0001, 1'b0);
    wait_done(16'hFFFF, 16'h0001, 1'b0, lat);
    finish(16'hFFFF, 16'h0001, 1'b0, 1'b0);

    // Slice ordering to the shared adder, LSB first
    start(16'h1234, 16'h4321, 1'b1);
    chk("busy_run", 32'(busy), 1);
    chk("start_ready_run", 32'(start_ready), 0);
    wait_done(16'h1234, 16'h4321, 1'b1, lat);
    for (int k = 0; k < NSLICE; k++) begin
      chk($sformatf("add_A_slice%0d", k), 32'(seq_a[k]), 32'((16'h1234 >> (4*k)) & 16'hF));
      chk($sformatf("add_B_slice%0d", k), 32'(seq_b[k]), 32'((16'h4321 >> (4*k)) & 16'hF));
    end
    chk("add_idle_in_done", 32'({add_A, add_B, add_Cin}), 0);
    finish(16'h1234, 16'h4321, 1'b1, 1'b0);
    chk("add_idle_in_idle", 32'({add_A, add_B, add_Cin}), 0);

    // Consumer stalls for 3 cycles; a new request during DONE is ignored
    done_ready = 1'b0;
    start(16'h8000, 16'h8000, 1'b0);
    wait_done(16'h8000, 16'h8000, 1'b0, lat);
    for (int k = 0; k < 3; k++) begin
      A = 16'h1111; B = 16'h1111; Cin = 1'b1; start_valid = 1'b1;
      tick();
      chk("stall_done_valid", 32'(done_valid), 1);
      chk("stall_S", 32'(S), 32'h0000);
      chk("stall_Cout", 32'(Cout), 1);
      chk("stall_start_ready", 32'(start_ready), 0);
    end
    start_valid = 1'b0; done_ready = 1'b1;
    tick();
    chk("after_stall_done_valid", 32'(done_valid), 0);
    chk("after_stall_start_ready", 32'(start_ready), 1);
    chk("after_stall_busy", 32'(busy), 0);

    // Reset mid-request, while slice 2 is on the adder
    start(16'hABCD, 16'h1234, 1'b1);
    tick(); tick();
    rst = 1'b1; #1;
    chk("midrst_S", 32'(S), 0);
    chk("midrst_Cout", 32'(Cout), 0);
    chk("midrst_done_valid", 32'(done_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_start_ready", 32'(start_ready), 1);
    chk("midrst_add", 32'({add_A, add_B, add_Cin}), 0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done_valid || busy) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 0);
    start(16'h00FF, 16'h0001, 1'b0);
    wait_done(16'h00FF, 16'h0001, 1'b0, lat);
    chk("post_rst_S", 32'(S), 32'h0100);
    finish(16'h00FF, 16'h0001, 1'b0, 1'b0);

    // Random back-to-back traffic with random consumer back-pressure
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (i % 10 == 0) begin ra = 16'hFFFF; rb = 16'($urandom_range(0, 2)); end
      start(ra, rb, rc);
      wait_done(ra, rb, rc, lat);
      finish(ra, rb, rc, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
